// File: rtl/mmss_countdown_timer_pkg.sv
// mmss_countdown_timer_pkg: shared states, digit widths/moduli and preset clamp helpers
package mmss_countdown_timer_pkg;
  localparam int UNITS_MOD = 10;
  localparam int TENS_MOD = 6;
  localparam int XU = 4;
  localparam int XT = 3;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;
  typedef struct packed {
    logic [XT-1:0] mt;
    logic [XU-1:0] mu;
    logic [XT-1:0] st;
    logic [XU-1:0] su;
  } mmss_t;
  function automatic logic [XU-1:0] clamp_u(input logic [XU-1:0] v);
    return (int'(v) >= UNITS_MOD) ? XU'(UNITS_MOD - 1) : v;
  endfunction
  function automatic logic [XT-1:0] clamp_t(input logic [XT-1:0] v);
    return (int'(v) >= TENS_MOD) ? XT'(TENS_MOD - 1) : v;
  endfunction
endpackage

// File: rtl/mmss_countdown_timer_down_digit.sv
// mmss_countdown_timer_down_digit: loadable BCD down-counter digit with borrow out
module mmss_countdown_timer_down_digit #(
  parameter int X = 4,
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic [X-1:0] ld_val,
  input  logic         en,
  output logic [X-1:0] count,
  output logic         borrow
);
  logic [X-1:0] count_q, count_d;
  // load wins over decrement; zero wraps to N-1 only when enabled
  always_comb count_d = ld ? ld_val : en ? ((count_q == '0) ? X'(N - 1) : count_q - X'(1)) : count_q;
  // digit register
  always_ff @(posedge clk or posedge reset)
    if (reset) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
  assign borrow = en & (count_q == '0);
endmodule

// File: rtl/mmss_countdown_timer.sv
// mmss_countdown_timer: loadable MM:SS countdown timer; define AUTO_RELOAD_EN for periodic reload from preset
module mmss_countdown_timer
  import mmss_countdown_timer_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          load,
  input  logic [XT-1:0] preset_mt,
  input  logic [XU-1:0] preset_mu,
  input  logic [XT-1:0] preset_st,
  input  logic [XU-1:0] preset_su,
  input  logic          start,
  input  logic          pause,
  output logic [XT-1:0] cnt_mt,
  output logic [XU-1:0] cnt_mu,
  output logic [XT-1:0] cnt_st,
  output logic [XU-1:0] cnt_su,
  output logic          running,
  output logic          done,
  output logic          expired
);
  state_t state_q, state_d;
  mmss_t preset_q, lv, nv, cnt;
  logic running_q, running_d, done_q, done_d, expired_q, expired_d;
  logic tick_run, cnt_zero, at_one, term, ld;
  logic [3:0] brw;
  assign lv = '{mt: clamp_t(preset_mt), mu: clamp_u(preset_mu), st: clamp_t(preset_st), su: clamp_u(preset_su)};
  assign cnt = '{mt: cnt_mt, mu: cnt_mu, st: cnt_st, su: cnt_su};
  // a borrow out of the minute-tens digit means a tick arrived at 00:00, which reloads instead of underflowing
  always_comb begin
    tick_run = state_q == RUN && tick && !load && !pause;
    cnt_zero = cnt == '0;
    at_one = cnt == mmss_t'(1);
    ld = load || brw[3];
    nv = load ? lv : preset_q;
`ifdef AUTO_RELOAD_EN
    term = brw[3] && preset_q == '0;
`else
    term = at_one || brw[3];
`endif
    state_d = load ? IDLE :
              (state_q == IDLE && start && !cnt_zero) ? RUN :
              (state_q == RUN && pause) ? PAUSE :
              (state_q == RUN && tick && term) ? EXPIRED :
              (state_q == PAUSE && start) ? RUN : state_q;
    done_d = tick_run && at_one;
    running_d = state_d == RUN;
    expired_d = state_d == EXPIRED;
  end
  // FSM state, preset register and registered status outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      preset_q <= '0;
      running_q <= 1'b0;
      done_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      preset_q <= nv;
      running_q <= running_d;
      done_q <= done_d;
      expired_q <= expired_d;
    end
  assign running = running_q;
  assign done = done_q;
  assign expired = expired_q;
  mmss_countdown_timer_down_digit #(.X(XU), .N(UNITS_MOD)) u_su (.clk(clk), .reset(reset), .ld(ld), .ld_val(nv.su), .en(tick_run), .count(cnt_su), .borrow(brw[0]));
  mmss_countdown_timer_down_digit #(.X(XT), .N(TENS_MOD)) u_st (.clk(clk), .reset(reset), .ld(ld), .ld_val(nv.st), .en(brw[0]), .count(cnt_st), .borrow(brw[1]));
  mmss_countdown_timer_down_digit #(.X(XU), .N(UNITS_MOD)) u_mu (.clk(clk), .reset(reset), .ld(ld), .ld_val(nv.mu), .en(brw[1]), .count(cnt_mu), .borrow(brw[2]));
  mmss_countdown_timer_down_digit #(.X(XT), .N(TENS_MOD)) u_mt (.clk(clk), .reset(reset), .ld(ld), .ld_val(nv.mt), .en(brw[2]), .count(cnt_mt), .borrow(brw[3]));
endmodule

// File: tb/tb_mmss_countdown_timer.sv
// tb_mmss_countdown_timer: scoreboard bench for the MM:SS countdown timer (AUTO_RELOAD_EN aware)
module tb_mmss_countdown_timer;
  logic clk = 0, reset = 1, tick = 0, load = 0, start = 0, pause = 0;
  logic [2:0] preset_mt = 0, preset_st = 0;
  logic [3:0] preset_mu = 0, preset_su = 0;
  logic [2:0] cnt_mt, cnt_st;
  logic [3:0] cnt_mu, cnt_su;
  logic running, done, expired;
  int total = 0, bad = 0;
  logic [16:0] eq[$];
  string nq[$];
  logic [16:0] act;
  always #5 clk = ~clk;
  mmss_countdown_timer dut (.clk(clk), .reset(reset), .tick(tick), .load(load), .preset_mt(preset_mt), .preset_mu(preset_mu), .preset_st(preset_st), .preset_su(preset_su), .start(start), .pause(pause), .cnt_mt(cnt_mt), .cnt_mu(cnt_mu), .cnt_st(cnt_st), .cnt_su(cnt_su), .running(running), .done(done), .expired(expired));
  assign act = {cnt_mt, cnt_mu, cnt_st, cnt_su, running, done, expired};
  function automatic logic [13:0] p(input int mt, mu, st, su);
    return {3'(mt), 4'(mu), 3'(st), 4'(su)};
  endfunction
  function automatic logic [16:0] e(input int mt, mu, st, su, input logic r, d, x);
    return {3'(mt), 4'(mu), 3'(st), 4'(su), r, d, x};
  endfunction
  task automatic step(input logic l, s, pa, t, input logic [13:0] pv, input logic [16:0] ex, input string nm);
    @(negedge clk);
    load = l; start = s; pause = pa; tick = t;
    {preset_mt, preset_mu, preset_st, preset_su} = pv;
    eq.push_back(ex);
    nq.push_back(nm);
  endtask
  always @(posedge clk) begin
    #1;
    if (eq.size() > 0) begin
      logic [16:0] w;
      string n;
      w = eq.pop_front();
      n = nq.pop_front();
      total++;
      if (act !== w) begin
        bad++;
        $display("FAIL %s got=%h want=%h", n, act, w);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [13:0] z;
    z = 0;
    @(negedge clk); @(negedge clk); reset = 0;
    step(0, 0, 0, 0, z, e(0, 0, 0, 0, 0, 0, 0), "reset_state");
    step(0, 1, 0, 0, z, e(0, 0, 0, 0, 0, 0, 0), "idle_start_zero");
    step(1, 0, 0, 0, p(0, 0, 0, 3), e(0, 0, 0, 3, 0, 0, 0), "load_0003");
    step(0, 1, 0, 0, z, e(0, 0, 0, 3, 1, 0, 0), "start_0003");
    step(0, 0, 0, 1, z, e(0, 0, 0, 2, 1, 0, 0), "tick_0002");
    step(0, 0, 0, 1, z, e(0, 0, 0, 1, 1, 0, 0), "tick_0001");
`ifdef AUTO_RELOAD_EN
    step(0, 0, 0, 1, z, e(0, 0, 0, 0, 1, 1, 0), "tick_0000_done");
    step(0, 0, 0, 0, z, e(0, 0, 0, 0, 1, 0, 0), "done_one_cycle");
    step(0, 0, 0, 1, z, e(0, 0, 0, 3, 1, 0, 0), "auto_reload_0003");
    step(1, 0, 0, 0, p(0, 0, 0, 2), e(0, 0, 0, 2, 0, 0, 0), "auto_load_0002");
    step(0, 1, 0, 0, z, e(0, 0, 0, 2, 1, 0, 0), "auto_start");
    step(0, 0, 0, 1, z, e(0, 0, 0, 1, 1, 0, 0), "auto_tick1");
    step(0, 0, 0, 1, z, e(0, 0, 0, 0, 1, 1, 0), "auto_tick2_done");
    step(0, 0, 0, 1, z, e(0, 0, 0, 2, 1, 0, 0), "auto_tick3_reload");
`else
    step(0, 0, 0, 1, z, e(0, 0, 0, 0, 0, 1, 1), "tick_0000_done");
    step(0, 0, 0, 0, z, e(0, 0, 0, 0, 0, 0, 1), "done_one_cycle");
    step(0, 0, 0, 1, z, e(0, 0, 0, 0, 0, 0, 1), "expired_tick");
    step(0, 1, 0, 0, z, e(0, 0, 0, 0, 0, 0, 1), "expired_start");
`endif
    step(1, 0, 0, 0, p(1, 0, 0, 0), e(1, 0, 0, 0, 0, 0, 0), "load_1000");
    step(0, 1, 0, 0, z, e(1, 0, 0, 0, 1, 0, 0), "start_1000");
    step(0, 0, 0, 1, z, e(0, 9, 5, 9, 1, 0, 0), "borrow_chain_0959");
    step(1, 0, 0, 0, p(0, 1, 0, 0), e(0, 1, 0, 0, 0, 0, 0), "load_0100");
    step(0, 1, 0, 0, z, e(0, 1, 0, 0, 1, 0, 0), "start_0100");
    for (int i = 1; i <= 5; i++) step(0, 0, 0, 1, z, e(0, 0, 5, 10 - i, 1, 0, 0), "tick_0100_run");
    step(0, 0, 1, 1, z, e(0, 0, 5, 5, 0, 0, 0), "pause_drops_tick");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, z, e(0, 0, 5, 5, 0, 0, 0), "paused_tick");
    step(0, 1, 0, 0, z, e(0, 0, 5, 5, 1, 0, 0), "resume");
    step(0, 0, 0, 1, z, e(0, 0, 5, 4, 1, 0, 0), "tick_0054");
    step(1, 1, 0, 1, p(0, 0, 0, 5), e(0, 0, 0, 5, 0, 0, 0), "load_drops_start_tick");
    step(0, 0, 0, 1, z, e(0, 0, 0, 5, 0, 0, 0), "idle_tick_ignored");
    step(1, 0, 0, 0, p(0, 0, 0, 0), e(0, 0, 0, 0, 0, 0, 0), "load_0000");
    step(0, 1, 0, 0, z, e(0, 0, 0, 0, 0, 0, 0), "start_at_zero");
    step(1, 0, 0, 0, p(6, 11, 7, 12), e(5, 9, 5, 9, 0, 0, 0), "clamp_preset");
    step(1, 0, 0, 0, p(0, 2, 3, 0), e(0, 2, 3, 0, 0, 0, 0), "load_0230");
    step(0, 1, 0, 0, z, e(0, 2, 3, 0, 1, 0, 0), "start_0230");
    step(0, 0, 0, 0, z, e(0, 2, 3, 0, 1, 0, 0), "hold_0230");
    @(posedge clk); #3;
    reset = 1;
    #1;
    total++;
    if (act !== 17'd0) begin
      bad++;
      $display("FAIL async_reset got=%h want=%h", act, 17'd0);
    end
    @(negedge clk); reset = 0;
    step(0, 0, 0, 1, z, e(0, 0, 0, 0, 0, 0, 0), "post_reset_idle");
    step(0, 1, 0, 0, z, e(0, 0, 0, 0, 0, 0, 0), "post_reset_start_zero");
    @(negedge clk); @(negedge clk);
    if (eq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", eq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
